// File: rtl/tile_pixel_fetcher_if.sv
// Purpose: request, graphic-lookup and pixel-stream signals of the tile pixel fetcher.
// Latency: none, wiring only.
// Backpressure: valid/ready on the request side and on the pixel side.
interface tile_pixel_fetcher_if #(
    parameter int REL_BITS         = 4,
    parameter int PIXEL_COLOR_BITS = 8,
    parameter int TILE_BITS        = 6,
    parameter int SCREEN_BITS      = 10
);
    // request side (tile scheduler)
    logic                        req_valid;
    logic                        req_ready;
    logic [TILE_BITS-1:0]        req_tile_x;
    logic [TILE_BITS-1:0]        req_tile_y;
    logic [1:0]                  req_sprite;
    logic                        req_transp;

    // graphic lookup side
    logic [1:0]                  sprite_sel;
    logic [REL_BITS-1:0]         rel_x;
    logic [REL_BITS-1:0]         rel_y;
    logic [PIXEL_COLOR_BITS-1:0] pixel_in;

    // pixel side (frame writer)
    logic                        pix_valid;
    logic                        pix_ready;
    logic [SCREEN_BITS-1:0]      pix_x;
    logic [SCREEN_BITS-1:0]      pix_y;
    logic [PIXEL_COLOR_BITS-1:0] pix_color;

    // status
    logic                        done;
    logic                        busy;

    // fetcher side
    modport master (
        input  req_valid, req_tile_x, req_tile_y, req_sprite, req_transp,
        output req_ready,
        output sprite_sel, rel_x, rel_y,
        input  pixel_in,
        output pix_valid, pix_x, pix_y, pix_color,
        input  pix_ready,
        output done, busy
    );

    // scheduler / graphic modules / frame writer side
    modport slave (
        output req_valid, req_tile_x, req_tile_y, req_sprite, req_transp,
        input  req_ready,
        input  sprite_sel, rel_x, rel_y,
        output pixel_in,
        input  pix_valid, pix_x, pix_y, pix_color,
        output pix_ready,
        input  done, busy
    );
endinterface

// File: rtl/tile_pixel_fetcher.sv
// Purpose: scan one tile graphic row-major and stream its pixels with absolute screen coordinates.
// Latency: first pixel valid 2 cycles after the request cycle; done pulses tile_area+2 cycles after it.
// Backpressure: pix_ready low with a held pixel freezes the scan counters and the output register.
module tile_pixel_fetcher #(
    parameter int                          PIXELS_WIDTH     = 16,
    parameter int                          REL_BITS         = 4,
    parameter int                          PIXEL_COLOR_BITS = 8,
    parameter int                          TILE_BITS        = 6,
    parameter int                          SCREEN_BITS      = 10,
    parameter logic [PIXEL_COLOR_BITS-1:0] TRANSPARENT      = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tile_pixel_fetcher_if.master bus
);

    localparam int                  CAT_BITS = TILE_BITS + REL_BITS;
    localparam logic [REL_BITS-1:0] REL_MAX  = REL_BITS'(PIXELS_WIDTH - 1);

    // DONE is a separate state so the done pulse comes straight from a flop
    // and the request port reopens only after it.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [TILE_BITS-1:0]        tile_x_q, tile_x_d;
    logic [TILE_BITS-1:0]        tile_y_q, tile_y_d;
    logic [1:0]                  sprite_q, sprite_d;
    logic                        transp_q, transp_d;
    logic [REL_BITS-1:0]         rel_x_q, rel_x_d;
    logic [REL_BITS-1:0]         rel_y_q, rel_y_d;
    logic                        pix_vld_q, pix_vld_d;
    logic [SCREEN_BITS-1:0]      pix_x_q, pix_x_d;
    logic [SCREEN_BITS-1:0]      pix_y_q, pix_y_d;
    logic [PIXEL_COLOR_BITS-1:0] pix_color_q, pix_color_d;

    logic                        can_load;
    logic                        last_px;
    logic                        skip_px;
    logic [CAT_BITS-1:0]         cat_x, cat_y;
    logic [SCREEN_BITS-1:0]      scr_x, scr_y;

    // Screen coordinate is tile*PIXELS_WIDTH + rel, i.e. a plain concatenation,
    // silently resized to the screen width.
    assign cat_x = {tile_x_q, rel_x_q};
    assign cat_y = {tile_y_q, rel_y_q};
    assign scr_x = SCREEN_BITS'(cat_x);
    assign scr_y = SCREEN_BITS'(cat_y);

    assign can_load = !pix_vld_q || bus.pix_ready;
    assign last_px  = (rel_x_q == REL_MAX) && (rel_y_q == REL_MAX);
    assign skip_px  = transp_q && (bus.pixel_in == TRANSPARENT);

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.sprite_sel = sprite_q;
    assign bus.rel_x      = rel_x_q;
    assign bus.rel_y      = rel_y_q;
    assign bus.pix_valid  = pix_vld_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_color  = pix_color_q;

    // State, latched request and output register; reset drops any held pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            sprite_q    <= '0;
            transp_q    <= 1'b0;
            rel_x_q     <= '0;
            rel_y_q     <= '0;
            pix_vld_q   <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
        end else begin
            state_q     <= state_d;
            tile_x_q    <= tile_x_d;
            tile_y_q    <= tile_y_d;
            sprite_q    <= sprite_d;
            transp_q    <= transp_d;
            rel_x_q     <= rel_x_d;
            rel_y_q     <= rel_y_d;
            pix_vld_q   <= pix_vld_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
        end
    end

    // Next-state: accept a request, scan with skip/backpressure, drain the last pixel.
    always_comb begin
        state_d     = state_q;
        tile_x_d    = tile_x_q;
        tile_y_d    = tile_y_q;
        sprite_d    = sprite_q;
        transp_d    = transp_q;
        rel_x_d     = rel_x_q;
        rel_y_d     = rel_y_q;
        pix_vld_d   = pix_vld_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    tile_x_d = bus.req_tile_x;
                    tile_y_d = bus.req_tile_y;
                    sprite_d = bus.req_sprite;
                    transp_d = bus.req_transp;
                    rel_x_d  = '0;
                    rel_y_d  = '0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (can_load) begin
                    if (skip_px) begin
                        pix_vld_d = 1'b0;
                    end else begin
                        pix_vld_d   = 1'b1;
                        pix_x_d     = scr_x;
                        pix_y_d     = scr_y;
                        pix_color_d = bus.pixel_in;
                    end
                    if (last_px) begin
                        state_d = S_DRAIN;
                    end else if (rel_x_q == REL_MAX) begin
                        rel_x_d = '0;
                        rel_y_d = rel_y_q + REL_BITS'(1);
                    end else begin
                        rel_x_d = rel_x_q + REL_BITS'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (can_load) begin
                    pix_vld_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tile_pixel_fetcher.sv
// Purpose: directed checks of the tile pixel fetcher against a hand-built expected pixel list.
// Latency: request cycle is cycle 0; done expected in cycle 258 for a 16x16 tile.
// Backpressure: pix_ready held high or toggled every cycle.
module tb_tile_pixel_fetcher;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tile_pixel_fetcher_if bus ();

    tile_pixel_fetcher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Graphic set: 0 all FF, 1 diagonal 00 rest FF, 2 only origin 5A rest 00, 3 all 00.
    function automatic logic [7:0] gfx(input logic [1:0] s, input logic [3:0] rx, input logic [3:0] ry);
        case (s)
            2'd0:    return 8'hFF;
            2'd1:    return (rx == ry) ? 8'h00 : 8'hFF;
            2'd2:    return (rx == 4'd0 && ry == 4'd0) ? 8'h5A : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.pixel_in = gfx(bus.sprite_sel, bus.rel_x, bus.rel_y);

    // Drives one request (cycle 0) and observes the tile until the cycle after done.
    task automatic run_tile(input logic [5:0] tx, input logic [5:0] ty, input logic [1:0] spr,
                            input logic tr, input bit toggle, input bit hold,
                            output int n_pix, output int seq_err, output int done_cnt,
                            output int done_cyc, output int stall_err, output int ready_err,
                            output logic ready_after);
        int         ex[256];
        int         ey[256];
        logic [7:0] ec[256];
        int         n_exp = 0;
        logic       pv = 1'b0, pr = 1'b0;
        logic [9:0] px = '0, py = '0;
        logic [7:0] pc = '0;
        for (int ry = 0; ry < 16; ry++) begin
            for (int rx = 0; rx < 16; rx++) begin
                logic [7:0] col;
                col = gfx(spr, 4'(rx), 4'(ry));
                if (!(tr && col == 8'h00)) begin
                    ex[n_exp] = int'(tx) * 16 + rx;
                    ey[n_exp] = int'(ty) * 16 + ry;
                    ec[n_exp] = col;
                    n_exp++;
                end
            end
        end
        n_pix = 0; seq_err = 0; done_cnt = 0; done_cyc = -1;
        stall_err = 0; ready_err = 0; ready_after = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (c == 0) begin
                bus.req_valid  = 1'b1;
                bus.req_tile_x = tx;
                bus.req_tile_y = ty;
                bus.req_sprite = spr;
                bus.req_transp = tr;
            end else if (hold) begin
                bus.req_tile_x = 6'(c + 5);
                bus.req_tile_y = 6'(c * 3);
            end else begin
                bus.req_valid = 1'b0;
            end
            bus.pix_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (pv && !pr && !(bus.pix_valid && bus.pix_x == px && bus.pix_y == py && bus.pix_color == pc))
                stall_err++;
            if (c == 0 ? !bus.req_ready : (done_cyc < 0 && bus.req_ready))
                ready_err++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (n_pix >= n_exp) seq_err++;
                else if (int'(bus.pix_x) != ex[n_pix] || int'(bus.pix_y) != ey[n_pix] || bus.pix_color != ec[n_pix])
                    seq_err++;
                n_pix++;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                ready_after = bus.req_ready;
                break;
            end
            pv = bus.pix_valid; pr = bus.pix_ready;
            px = bus.pix_x; py = bus.pix_y; pc = bus.pix_color;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_tile_x = '0; bus.req_tile_y = '0;
        bus.req_sprite = '0; bus.req_transp = 1'b0; bus.pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", bus.req_ready); end
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%b want=0", bus.pix_valid); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if ({bus.rel_x, bus.rel_y} !== 8'h00) begin bad++; $display("FAIL rst_rel got=%h want=00", {bus.rel_x, bus.rel_y}); end
        total++; if (bus.sprite_sel !== 2'd0) begin bad++; $display("FAIL rst_sprite_sel got=%0d want=0", bus.sprite_sel); end
        total++; if ({bus.pix_x, bus.pix_y, bus.pix_color} !== 28'h0) begin bad++; $display("FAIL rst_pix got=%h want=0", {bus.pix_x, bus.pix_y, bus.pix_color}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_full_tile;
        int n, se, dc, dy, st, re; logic ra;
        run_tile(6'd2, 6'd3, 2'd0, 1'b0, 1'b0, 1'b0, n, se, dc, dy, st, re, ra);
        total++; if (n != 256) begin bad++; $display("FAIL full_count got=%0d want=256", n); end
        total++; if (se != 0) begin bad++; $display("FAIL full_seq errors=%0d want=0", se); end
        total++; if (dc != 1) begin bad++; $display("FAIL full_done_cnt got=%0d want=1", dc); end
        total++; if (dy != 258) begin bad++; $display("FAIL full_done_cycle got=%0d want=258", dy); end
        total++; if (ra !== 1'b1) begin bad++; $display("FAIL full_ready_after_done got=%b want=1", ra); end
        total++; if (re != 0) begin bad++; $display("FAIL full_req_ready errors=%0d want=0", re); end
    endtask

    task automatic test_backpressure;
        int n, se, dc, dy, st, re; logic ra;
        run_tile(6'd2, 6'd3, 2'd0, 1'b0, 1'b1, 1'b0, n, se, dc, dy, st, re, ra);
        total++; if (n != 256) begin bad++; $display("FAIL bp_count got=%0d want=256", n); end
        total++; if (se != 0) begin bad++; $display("FAIL bp_seq errors=%0d want=0", se); end
        total++; if (dc != 1) begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", dc); end
        total++; if (st != 0) begin bad++; $display("FAIL bp_stall_stable errors=%0d want=0", st); end
    endtask

    task automatic test_transparency;
        int n, se, dc, dy, st, re; logic ra;
        run_tile(6'd5, 6'd1, 2'd1, 1'b1, 1'b0, 1'b0, n, se, dc, dy, st, re, ra);
        total++; if (n != 240) begin bad++; $display("FAIL diag_count got=%0d want=240", n); end
        total++; if (se != 0) begin bad++; $display("FAIL diag_seq errors=%0d want=0", se); end
        total++; if (dy != 258) begin bad++; $display("FAIL diag_done_cycle got=%0d want=258", dy); end
        run_tile(6'd5, 6'd1, 2'd1, 1'b0, 1'b0, 1'b0, n, se, dc, dy, st, re, ra);
        total++; if (n != 256) begin bad++; $display("FAIL diag_opaque_count got=%0d want=256", n); end
        total++; if (se != 0) begin bad++; $display("FAIL diag_opaque_seq errors=%0d want=0", se); end
        run_tile(6'd7, 6'd9, 2'd2, 1'b1, 1'b0, 1'b0, n, se, dc, dy, st, re, ra);
        total++; if (n != 1) begin bad++; $display("FAIL origin_count got=%0d want=1", n); end
        total++; if (se != 0) begin bad++; $display("FAIL origin_seq errors=%0d want=0", se); end
        total++; if (dy != 258) begin bad++; $display("FAIL origin_done_cycle got=%0d want=258", dy); end
        run_tile(6'd1, 6'd1, 2'd3, 1'b1, 1'b0, 1'b0, n, se, dc, dy, st, re, ra);
        total++; if (n != 0) begin bad++; $display("FAIL empty_count got=%0d want=0", n); end
        total++; if (dc != 1) begin bad++; $display("FAIL empty_done_cnt got=%0d want=1", dc); end
        total++; if (dy != 258) begin bad++; $display("FAIL empty_done_cycle got=%0d want=258", dy); end
    endtask

    task automatic test_back_to_back;
        int n, se, dc, dy, st, re; logic ra;
        bit seen = 1'b0;
        run_tile(6'd4, 6'd1, 2'd0, 1'b0, 1'b0, 1'b1, n, se, dc, dy, st, re, ra);
        total++; if (n != 256) begin bad++; $display("FAIL hold_count got=%0d want=256", n); end
        total++; if (se != 0) begin bad++; $display("FAIL hold_seq errors=%0d want=0", se); end
        total++; if (re != 0) begin bad++; $display("FAIL hold_req_ready errors=%0d want=0", re); end
        total++; if (dy != 258) begin bad++; $display("FAIL hold_done_cycle got=%0d want=258", dy); end
        // request at cycle 259 carries tile (8,9)
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL hold_next_busy got=%b want=1", bus.busy); end
        @(posedge clk); #1;
        total++; if (bus.pix_valid !== 1'b1) begin bad++; $display("FAIL hold_next_valid got=%b want=1", bus.pix_valid); end
        total++; if (bus.pix_x !== 10'd128) begin bad++; $display("FAIL hold_next_x got=%0d want=128", bus.pix_x); end
        total++; if (bus.pix_y !== 10'd144) begin bad++; $display("FAIL hold_next_y got=%0d want=144", bus.pix_y); end
        for (int c = 0; c < 400 && !seen; c++) begin
            if (bus.done) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (!seen) begin bad++; $display("FAIL hold_next_done got=0 want=1"); end
    endtask

    task automatic test_reset_mid;
        int n, se, dc, dy, st, re; logic ra;
        int cnt = 0;
        bit seen = 1'b0;
        bus.req_valid = 1'b1; bus.req_tile_x = 6'd2; bus.req_tile_y = 6'd3;
        bus.req_sprite = 2'd1; bus.req_transp = 1'b0; bus.pix_ready = 1'b1;
        for (int c = 0; c < 400 && cnt < 100; c++) begin
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.pix_valid && bus.pix_ready) cnt++;
            @(posedge clk); #1;
        end
        bus.pix_ready = 1'b0;
        total++; if (bus.pix_valid !== 1'b1) begin bad++; $display("FAIL mid_held_valid got=%b want=1", bus.pix_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", bus.pix_valid); end
        total++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ready_busy got=%b%b want=10", bus.req_ready, bus.busy); end
        total++; if ({bus.rel_x, bus.rel_y} !== 8'h00) begin bad++; $display("FAIL mid_rst_rel got=%h want=00", {bus.rel_x, bus.rel_y}); end
        total++; if (bus.sprite_sel !== 2'd0) begin bad++; $display("FAIL mid_rst_sprite got=%0d want=0", bus.sprite_sel); end
        total++; if ({bus.pix_x, bus.pix_y, bus.pix_color} !== 28'h0) begin bad++; $display("FAIL mid_rst_pix got=%h want=0", {bus.pix_x, bus.pix_y, bus.pix_color}); end
        for (int c = 0; c < 4; c++) begin
            if (bus.done) seen = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (bus.done) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_rst_no_done got=1 want=0"); end
        run_tile(6'd2, 6'd3, 2'd0, 1'b0, 1'b0, 1'b0, n, se, dc, dy, st, re, ra);
        total++; if (n != 256) begin bad++; $display("FAIL after_rst_count got=%0d want=256", n); end
        total++; if (se != 0) begin bad++; $display("FAIL after_rst_seq errors=%0d want=0", se); end
        total++; if (dy != 258) begin bad++; $display("FAIL after_rst_done_cycle got=%0d want=258", dy); end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_backpressure();
        test_transparency();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_pixel_fetcher.md
# tile_pixel_fetcher

Reads one tile graphic (ghost box, wall, pellet, etc.) pixel by pixel and streams the pixels out with absolute screen coordinates toward the frame writer. It issues relative (x, y) addresses to the combinational graphic lookup modules and samples their `pixels` output. It sits between the maze/tile scheduler (request side) and the framebuffer write port (pixel side), and uses valid/ready on both sides.

## Interface
- `PIXELS_WIDTH`, default 16: tile edge in pixels; must be a power of two.
- `REL_BITS`, default 4: log2(`PIXELS_WIDTH`); width of the relative coordinates.
- `PIXEL_COLOR_BITS`, default 8: colour width.
- `TILE_BITS`, default 6: tile grid coordinate width.
- `SCREEN_BITS`, default 10: absolute screen coordinate width.
- `TRANSPARENT`, default 8'h00: colour that is skipped when transparency is enabled.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: tile request present.
- `req_ready`  out  1: fetcher can accept a request.
- `req_tile_x`  in  TILE_BITS: tile column.
- `req_tile_y`  in  TILE_BITS: tile row.
- `req_sprite`  in  2: graphic source select.
- `req_transp`  in  1: enable transparency skipping.
- `sprite_sel`  out  2: latched `req_sprite`, drives the external graphic mux.
- `rel_x`  out  REL_BITS: relative x address to the graphic modules.
- `rel_y`  out  REL_BITS: relative y address to the graphic modules.
- `pixel_in`  in  PIXEL_COLOR_BITS: muxed graphic output, combinational from `rel_x`, `rel_y` and `sprite_sel`.
- `pix_valid`  out  1: output pixel valid.
- `pix_ready`  in  1: sink accepts the pixel.
- `pix_x`  out  SCREEN_BITS: absolute screen x.
- `pix_y`  out  SCREEN_BITS: absolute screen y.
- `pix_color`  out  PIXEL_COLOR_BITS: pixel colour.
- `done`  out  1: one-cycle pulse when the last pixel of a tile has been accepted.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. When `req_valid` is high, latch tile_x, tile_y, sprite and transp; clear the counters; go to SCAN.
  - SCAN: `rel_x` and `rel_y` are driven from the counters.
    - The output register "can load" when `pix_valid`=0 or `pix_ready`=1.
    - When it can load: sample `pixel_in`. If transp=1 and `pixel_in`==TRANSPARENT, no pixel is emitted that cycle (`pix_valid` goes to 0 if it was consumed). Otherwise load `pix_color`, `pix_x`, `pix_y` and set `pix_valid`=1.
    - In either case the counters advance on a load cycle.
    - When the current pixel is the last one (rel_x = rel_y = PIXELS_WIDTH-1), go to DRAIN instead of advancing.
  - DRAIN: no new loads. When `pix_valid`=0, or `pix_valid`=1 with `pix_ready`=1: pulse `done`, go to IDLE.
- Scan order is row-major: `rel_x` is the inner counter, `rel_y` the outer. `rel_x` wraps from PIXELS_WIDTH-1 to 0 and increments `rel_y` at the same time.
- Coordinate arithmetic:
  - `pix_x` = {tile_x, rel_x} (tile_x·PIXELS_WIDTH + rel_x), zero-extended or truncated to SCREEN_BITS. `pix_y` is formed the same way from tile_y and rel_y.
  - Truncation is silent; no overflow flag.
- Pixel count: exactly PIXELS_WIDTH² pixels are examined per request. The number emitted equals that count minus the number of skipped transparent pixels.
- `pix_x`, `pix_y`, `pix_color` hold stable while `pix_valid`=1 and `pix_ready`=0.
- `req_*` inputs are ignored outside IDLE. `req_ready` is 0 in SCAN and DRAIN, so no request is lost.

## Timing
- Reset (async assert, synchronous release effect) returns the block to IDLE. Reset values:
  - `req_ready`=1, `pix_valid`=0, `done`=0, `busy`=0.
  - `rel_x`=`rel_y`=0, `sprite_sel`=0, `pix_x`=`pix_y`=0, `pix_color`=0.
- Reset mid-tile abandons the tile with no `done` pulse; any held pixel is dropped.
- Request acceptance takes one cycle (IDLE→SCAN). The first pixel is valid in the cycle after the first SCAN cycle. Latency from the accepting `req_valid` edge to `pix_valid`=1 is 2 cycles.
- With `pix_ready` held at 1 and no skips: one pixel per cycle. `done` pulses PIXELS_WIDTH²+2 cycles after the request is accepted, and `req_ready` returns the cycle after `done`.
- Backpressure: while `pix_ready`=0 and `pix_valid`=1, the counters and `rel_x`/`rel_y` freeze.
- `pixel_in` must settle combinationally within the same cycle as `rel_x`/`rel_y`.
- If the last pixel is skipped as transparent, DRAIN sees `pix_valid`=0 and `done` fires one cycle later.

## Test plan
- Reset, then request tile (2,3), sprite 0 = all 8'hFF, transp=0, `pix_ready`=1 → 256 pixels. First pixel is (32,48), last is (47,63), all colour FF. `done` fires exactly once, 258 cycles after acceptance.
- Same request with `pix_ready` toggling 1/0 every cycle → the same 256-pixel sequence in order, no duplicates or drops, and outputs stable during stalls.
- Sprite whose diagonal is 8'h00 (rest FF), transp=1 → 240 pixels emitted and no pixel where rel_x==rel_y. With transp=0 → 256 pixels.
- Sprite whose only non-transparent pixel is (0,0), transp=1 → a single pixel at tile origin, then `done`. Also an all-transparent sprite → zero pixels, `done` still pulses once.
- `req_valid` held high continuously with changing tile coords → the next request is latched only the cycle after `done`, and coordinates change mid-tile are ignored.
- Assert `rst_n`=0 at pixel 100 with `pix_ready`=0 → all outputs take their reset values immediately and no `done` pulse. A new request after release restarts at rel (0,0).
